// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_access_arbiter
// Purpose  : Front-end for a single-port RAM with a 1-cycle registered read.
//            Merges a write request stream and a read request stream onto the
//            RAM's single addr/data/write_ena port, one operation per cycle,
//            and returns read data on a response stream with valid/ready
//            backpressure (at most one response outstanding).
// Ports    : clk, rst_n                 clock, async active-low reset
//            wr_valid/wr_ready/wr_addr/wr_data   write request stream
//            rd_valid/rd_ready/rd_addr           read request stream
//            rsp_valid/rsp_ready/rsp_data        read response stream
//            ram_data/ram_addr/ram_write_ena     drive to RAM
//            ram_q                               RAM registered read data
// Config   : ARB_FIXED_PRIO_EN - when defined, a write always wins a tie
//            (reads may starve); otherwise ties alternate round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module ram_access_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADD_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADD_WIDTH-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADD_WIDTH-1:0]  rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADD_WIDTH-1:0]  ram_addr,
    output logic                  ram_write_ena,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    // Response state encoding
    localparam logic [1:0] c_ST_EMPTY = 2'd0;  // nothing outstanding
    localparam logic [1:0] c_ST_LIVE  = 2'd1;  // response taken straight from ram_q
    localparam logic [1:0] c_ST_HELD  = 2'd2;  // response parked in hold register

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [ADD_WIDTH-1:0]  r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_data;
    logic                  w_rd_ok;
    logic                  w_grant_wr;
    logic                  w_grant_rd;
    logic                  w_capture;

`ifndef ARB_FIXED_PRIO_EN
    // 1 = last grant went to the write side. Resets to "read" so the first
    // tie goes to the write.
    logic                  r_last_grant_wr;
`endif

    // A read may only issue if the response slot will be free at the next
    // edge: either nothing is outstanding or the consumer takes it now.
    assign w_rd_ok = (r_state == c_ST_EMPTY) || rsp_ready;

    // ------------------------------------------------------------------
    // Grant logic
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        if (rst_n) begin
            if (wr_valid && rd_valid && w_rd_ok) begin
`ifdef ARB_FIXED_PRIO_EN
                w_grant_wr = 1'b1;
`else
                w_grant_wr = !r_last_grant_wr;
                w_grant_rd = r_last_grant_wr;
`endif
            end else if (wr_valid) begin
                // Writes never wait on response backpressure.
                w_grant_wr = 1'b1;
            end else if (rd_valid && w_rd_ok) begin
                w_grant_rd = 1'b1;
            end
        end
    end

    assign wr_ready      = w_grant_wr;
    assign rd_ready      = w_grant_rd;
    assign ram_write_ena = w_grant_wr;

    // When idle the RAM port keeps its last address/data, so ram_q keeps
    // reading the last-addressed word.
    always_comb begin
        ram_addr = r_ram_addr;
        ram_data = r_ram_data;
        if (w_grant_wr) begin
            ram_addr = wr_addr;
            ram_data = wr_data;
        end else if (w_grant_rd) begin
            ram_addr = rd_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_addr <= '0;
            r_ram_data <= '0;
        end else begin
            r_ram_addr <= ram_addr;
            r_ram_data <= ram_data;
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant_wr <= 1'b0;
        end else if (w_grant_wr || w_grant_rd) begin
            r_last_grant_wr <= w_grant_wr;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Response FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Response FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_EMPTY: begin
                if (w_grant_rd) begin
                    w_state_next = c_ST_LIVE;
                end
            end
            c_ST_LIVE, c_ST_HELD: begin
                if (rsp_ready) begin
                    w_state_next = w_grant_rd ? c_ST_LIVE : c_ST_EMPTY;
                end else begin
                    // ram_q moves on next cycle, so a stalled live
                    // response must be parked in the hold register.
                    w_state_next = c_ST_HELD;
                end
            end
            default: begin
                w_state_next = c_ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        rsp_valid = 1'b0;
        rsp_data  = r_hold;
        w_capture = 1'b0;
        case (r_state)
            c_ST_LIVE: begin
                rsp_valid = 1'b1;
                rsp_data  = ram_q;
                w_capture = !rsp_ready;
            end
            c_ST_HELD: begin
                rsp_valid = 1'b1;
                rsp_data  = r_hold;
            end
            default: begin
                rsp_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (w_capture) begin
            r_hold <= ram_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_access_arbiter
// Purpose  : Self-checking bench for ram_access_arbiter with a behavioural
//            single-port RAM (1-cycle registered read). Expected read data is
//            queued when a read is granted; a monitor pops and compares on
//            every response handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_access_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_valid = 1'b0;
    logic       rd_ready;
    logic [7:0] rd_addr = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic [7:0] ram_data;
    logic [7:0] ram_addr;
    logic       ram_write_ena;
    logic [7:0] ram_q = '0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem [256];

    always #5 clk = ~clk;

    ram_access_arbiter #(.DATA_WIDTH(8), .ADD_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .ram_data     (ram_data),
        .ram_addr     (ram_addr),
        .ram_write_ena(ram_write_ena),
        .ram_q        (ram_q)
    );

    // Behavioural single-port RAM: contents survive arbiter reset.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (ram_write_ena) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor / scoreboard
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
            end else begin
                chk("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // One bus cycle: drive just after posedge, return at negedge.
    task automatic cyc(input logic wv, input logic [7:0] wa, input logic [7:0] wd,
                       input logic rv, input logic [7:0] ra, input logic [7:0] rexp,
                       input logic rr);
        @(posedge clk);
        #1;
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        rd_valid  = rv;
        rd_addr   = ra;
        rsp_ready = rr;
        @(negedge clk);
        if (rv && rd_ready) exp_q.push_back(rexp);
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  wi;
        logic exp_w;

        // ---------------- Test 1: reset behaviour ----------------
        wr_valid = 1'b1;
        wr_addr  = 8'h01;
        #12;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_ram_we", 32'(ram_write_ena), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_valid = 1'b0;
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 8'h00, 1'b1);
        chk("t1_rd_ready", 32'(rd_ready), 1);
        @(posedge clk);
        #1;
        rd_valid  = 1'b0;
        rsp_ready = 1'b0;
        chk("t1_live_before_rst", 32'(rsp_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t1_rsp_dropped", 32'(rsp_valid), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t1_empty_after_rst", 32'(rsp_valid), 0);

        // ---------------- Test 2: write then read ----------------
        cyc(1'b1, 8'h10, 8'h5A, 1'b0, 8'h00, 8'h00, 1'b1);
        chk("t2_wr_ready", 32'(wr_ready), 1);
        chk("t2_ram_we", 32'(ram_write_ena), 1);
        chk("t2_ram_addr_w", 32'(ram_addr), 32'h10);
        chk("t2_ram_data", 32'(ram_data), 32'h5A);
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 8'h5A, 1'b1);
        chk("t2_rd_ready", 32'(rd_ready), 1);
        chk("t2_ram_we_rd", 32'(ram_write_ena), 0);
        chk("t2_ram_addr_r", 32'(ram_addr), 32'h10);
        idle();
        chk("t2_rsp_valid_lat1", 32'(rsp_valid), 1);
        chk("t2_rsp_data_lat1", 32'(rsp_data), 32'h5A);
        idle();
        chk("t2_empty", 32'(rsp_valid), 0);
        chk("t2_idle_addr_hold", 32'(ram_addr), 32'h10);

        // ---------------- Test 3: tie arbitration ----------------
        wi = 0;
        for (int c = 0; c < 4; c++) begin
            cyc(1'b1, 8'(8'h20 + wi), 8'(wi), 1'b1, 8'h30, 8'h00, 1'b1);
`ifdef ARB_FIXED_PRIO_EN
            exp_w = 1'b1;
`else
            exp_w = (c % 2 == 0);
`endif
            chk("t3_tie_wr_ready", 32'(wr_ready), 32'(exp_w));
            chk("t3_tie_rd_ready", 32'(rd_ready), 32'(!exp_w));
            if (wr_ready) wi++;
        end
        idle();
        idle();
        chk("t3_empty", 32'(rsp_valid), 0);

        // ---------------- Test 4: backpressure hold ----------------
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 8'h5A, 1'b0);
        chk("t4_rd_ready", 32'(rd_ready), 1);
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, 8'h10, 8'hFF, 1'b1, 8'h10, 8'hEE, 1'b0);
            chk("t4_wr_ready", 32'(wr_ready), 1);
            chk("t4_rd_blocked", 32'(rd_ready), 0);
            chk("t4_rsp_valid", 32'(rsp_valid), 1);
            chk("t4_rsp_held", 32'(rsp_data), 32'h5A);
        end
        idle();
        chk("t4_release_valid", 32'(rsp_valid), 1);
        chk("t4_release_data", 32'(rsp_data), 32'h5A);
        idle();
        chk("t4_empty", 32'(rsp_valid), 0);

        // ---------------- Test 5: back-to-back reads ----------------
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 8'(i), 8'(8'h80 + i), 1'b0, 8'h00, 8'h00, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'(i), 8'(8'h80 + i), 1'b1);
            chk("t5_rd_ready", 32'(rd_ready), 1);
            if (i > 0) chk("t5_rsp_stream", 32'(rsp_valid), 1);
        end
        idle();
        chk("t5_last_rsp", 32'(rsp_valid), 1);
        idle();
        chk("t5_empty", 32'(rsp_valid), 0);

        // ---------------- Test 6: address extremes ----------------
        cyc(1'b1, 8'hFF, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b1);
        chk("t6_addr_ff", 32'(ram_addr), 32'hFF);
        cyc(1'b1, 8'h00, 8'h3C, 1'b0, 8'h00, 8'h00, 1'b1);
        chk("t6_addr_00", 32'(ram_addr), 32'h00);
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 8'hA5, 1'b1);
        chk("t6_rd_addr_ff", 32'(ram_addr), 32'hFF);
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h3C, 1'b1);
        chk("t6_rd_addr_00", 32'(ram_addr), 32'h00);
        idle();
        idle();
        idle();

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
